// File: rtl/rgb_pwm_sequencer_if.sv
// Configuration write port of the RGB PWM sequencer: one channel setting per valid/ready handshake.
// The master drives a write and holds it until cfg_ready is seen; the slave accepts when both are high.
interface rgb_pwm_sequencer_if #(
    parameter int NCH   = 3,
    parameter int PWM_W = 8
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PWM_W-1:0] cfg_duty;
    logic [7:0]       cfg_rate;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
        output cfg_ready
    );
endinterface

// File: rtl/rgb_pwm_sequencer.sv
// Per-channel LED PWM engine (OFF/STATIC/BLINK/BREATHE); a write lands on pwm at frame_start+1 of the next frame.
// Single pending config slot: cfg_ready drops after an accept and returns the cycle after the committing frame_start.
module rgb_pwm_sequencer #(
    parameter int NCH      = 3,
    parameter int PWM_W    = 8,
    parameter int TICK_DIV = 188
) (
    input  logic               clk,
    input  logic               rst,
    rgb_pwm_sequencer_if.slave cfg,
    output logic [NCH-1:0]     pwm,
    output logic               frame_start
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        mode_e            mode;
        logic [PWM_W-1:0] duty;
        logic [7:0]       rate;
    } cfg_t;

    logic [PS_W-1:0]  presc_q;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic             tick;

    logic             pend_vld_q;
    cfg_t             pend_q;
    logic             cfg_acc;

    mode_e            mode_q     [NCH];
    mode_e            mode_d     [NCH];
    logic [PWM_W-1:0] duty_q     [NCH];
    logic [PWM_W-1:0] duty_d     [NCH];
    logic [PWM_W-1:0] level_q    [NCH];
    logic [PWM_W-1:0] level_d    [NCH];
    logic [7:0]       rate_q     [NCH];
    logic [7:0]       rate_d     [NCH];
    logic [7:0]       rate_cnt_q [NCH];
    logic [7:0]       rate_cnt_d [NCH];
    logic             dir_up_q   [NCH];
    logic             dir_up_d   [NCH];
    logic [NCH-1:0]   step;

    assign tick          = (presc_q == PS_MAX);
    assign cfg.cfg_ready = !pend_vld_q && !rst;
    assign cfg_acc       = cfg.cfg_valid && cfg.cfg_ready;

    // Next channel state; only a frame_start cycle may change anything, so each frame carries one duty.
    always_comb begin
        step = '0;
        for (int i = 0; i < NCH; i++) begin
            mode_d[i]     = mode_q[i];
            duty_d[i]     = duty_q[i];
            rate_d[i]     = rate_q[i];
            rate_cnt_d[i] = rate_cnt_q[i];
            dir_up_d[i]   = dir_up_q[i];
            level_d[i]    = level_q[i];
            if (frame_start) begin
                if (pend_vld_q && (pend_q.ch == CH_W'(i))) begin
                    mode_d[i]     = pend_q.mode;
                    duty_d[i]     = pend_q.duty;
                    rate_d[i]     = pend_q.rate;
                    rate_cnt_d[i] = 8'd0;
                    dir_up_d[i]   = 1'b1;
                    if ((pend_q.mode == MODE_STATIC) || (pend_q.mode == MODE_BLINK))
                        level_d[i] = pend_q.duty;
                    else
                        level_d[i] = '0;
                end else begin
                    if (rate_cnt_q[i] == rate_q[i]) begin
                        rate_cnt_d[i] = 8'd0;
                        step[i]       = 1'b1;
                    end else begin
                        rate_cnt_d[i] = rate_cnt_q[i] + 8'd1;
                    end
                    if (step[i]) begin
                        case (mode_q[i])
                            MODE_BLINK: begin
                                level_d[i] = (level_q[i] == '0) ? duty_q[i] : '0;
                            end
                            MODE_BREATHE: begin
                                if (duty_q[i] == '0) begin
                                    level_d[i] = '0;
                                end else if (dir_up_q[i]) begin
                                    level_d[i] = level_q[i] + PWM_W'(1);
                                    if (level_d[i] == duty_q[i])
                                        dir_up_d[i] = 1'b0;
                                end else begin
                                    level_d[i] = level_q[i] - PWM_W'(1);
                                    if (level_d[i] == '0)
                                        dir_up_d[i] = 1'b1;
                                end
                            end
                            default: begin
                                level_d[i] = level_q[i];
                            end
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            frame_start <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            pwm         <= '0;
            for (int i = 0; i < NCH; i++) begin
                mode_q[i]     <= MODE_OFF;
                duty_q[i]     <= '0;
                level_q[i]    <= '0;
                rate_q[i]     <= 8'd0;
                rate_cnt_q[i] <= 8'd0;
                dir_up_q[i]   <= 1'b1;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + PS_W'(1);
            if (tick)
                pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            frame_start <= tick && (pwm_cnt_q == '1);

            // Accept and commit never coincide: cfg_ready is low whenever a write is pending.
            if (cfg_acc) begin
                pend_vld_q <= 1'b1;
                pend_q     <= '{ch:   cfg.cfg_ch,
                                mode: mode_e'(cfg.cfg_mode),
                                duty: cfg.cfg_duty,
                                rate: cfg.cfg_rate};
            end else if (frame_start) begin
                pend_vld_q <= 1'b0;
            end

            for (int i = 0; i < NCH; i++) begin
                mode_q[i]     <= mode_d[i];
                duty_q[i]     <= duty_d[i];
                level_q[i]    <= level_d[i];
                rate_q[i]     <= rate_d[i];
                rate_cnt_q[i] <= rate_cnt_d[i];
                dir_up_q[i]   <= dir_up_d[i];
                // Compare against the post-commit level so the first tick of a frame already uses it.
                pwm[i]        <= (level_d[i] > pwm_cnt_q);
            end
        end
    end
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer at PWM_W=4, TICK_DIV=2 (32-clock frames): frame-level model plus directed duty counts.
module tb_rgb_pwm_sequencer;
    localparam int NCH   = 3;
    localparam int PWM_W = 4;
    localparam int FRAME = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] pwm;
    logic           frame_start;

    always #5 clk = ~clk;

    rgb_pwm_sequencer_if #(.NCH(NCH), .PWM_W(PWM_W)) cfg_if ();

    rgb_pwm_sequencer #(.NCH(NCH), .PWM_W(PWM_W), .TICK_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .pwm         (pwm),
        .frame_start (frame_start)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level reference: time since reset gives the counter, frames since commit give the level.
    bit             mvalid = 1'b0;
    bit             m_rdy;
    int             t;
    bit             mpend;
    int             mp_ch, mp_mode, mp_duty, mp_rate;
    int             mmode [NCH];
    int             mduty [NCH];
    int             mrate [NCH];
    int             mfr   [NCH];
    logic [NCH-1:0] exp_pwm;
    bit             exp_fs;

    function automatic int mlevel(input int c);
        int steps, p;
        steps = mfr[c] / (mrate[c] + 1);
        case (mmode[c])
            1: return mduty[c];
            2: return (steps % 2 == 0) ? mduty[c] : 0;
            3: begin
                if (mduty[c] == 0) return 0;
                p = steps % (2 * mduty[c]);
                return (p <= mduty[c]) ? p : 2 * mduty[c] - p;
            end
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            mpend = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                mmode[c] = 0; mduty[c] = 0; mrate[c] = 0; mfr[c] = 0;
            end
            exp_pwm = '0;
            exp_fs  = 1'b0;
            mvalid  = 1'b1;
        end else if (mvalid) begin
            m_rdy = !mpend;
            if (t > 0 && t % FRAME == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    if (mpend && mp_ch == c) begin
                        mmode[c] = mp_mode; mduty[c] = mp_duty; mrate[c] = mp_rate; mfr[c] = 0;
                    end else begin
                        mfr[c]++;
                    end
                end
                mpend = 1'b0;
            end
            for (int c = 0; c < NCH; c++)
                exp_pwm[c] = (mlevel(c) > ((t / 2) % 16));
            if (cfg_if.cfg_valid && m_rdy) begin
                mpend   = 1'b1;
                mp_ch   = int'(cfg_if.cfg_ch);
                mp_mode = int'(cfg_if.cfg_mode);
                mp_duty = int'(cfg_if.cfg_duty);
                mp_rate = int'(cfg_if.cfg_rate);
            end
            t++;
            exp_fs = (t % FRAME == 0);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("pwm", int'(pwm), int'(exp_pwm));
            check("frame_start", int'(frame_start), int'(exp_fs));
            check("cfg_ready", int'(cfg_if.cfg_ready), int'(!mpend && !rst));
        end
    end

    int meas [8];

    task automatic wait_fs();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", int'(frame_start), 1);
    endtask

    // Counts clocks per frame with (pwm & mask) != 0 over the nfr frames following the next frame_start.
    task automatic measure(input int mask, input int nfr);
        int cnt;
        wait_fs();
        for (int k = 0; k < nfr; k++) begin
            cnt = 0;
            repeat (FRAME) begin
                @(negedge clk);
                if ((int'(pwm) & mask) != 0) cnt++;
            end
            meas[k] = cnt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int duty, input int rate,
                             output int acc_cyc, output int fs_cyc);
        int n = 0;
        fs_cyc = -1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_mode  = 2'(mode);
        cfg_if.cfg_duty  = 4'(duty);
        cfg_if.cfg_rate  = 8'(rate);
        @(negedge clk);
        if (frame_start) fs_cyc = cyc;
        while (!cfg_if.cfg_ready && n < 4 * FRAME) begin
            @(negedge clk);
            if (frame_start) fs_cyc = cyc;
            n++;
        end
        check("write_accept", int'(cfg_if.cfg_ready), 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, f1, a2, f2, c0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_duty  = '0;
        cfg_if.cfg_rate  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_ready", int'(cfg_if.cfg_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(cfg_if.cfg_ready), 1);

        wait_fs();
        c0 = cyc;
        wait_fs();
        check("frame_period", cyc - c0, FRAME);
        @(posedge clk);
        #1;

        cfg_write(0, 1, 4, 0, a1, f1);
        measure(1, 1);
        check("static_duty4", meas[0], 8);
        cfg_write(0, 1, 0, 0, a1, f1);
        measure(1, 1);
        check("static_duty0", meas[0], 0);
        cfg_write(0, 1, 15, 0, a1, f1);
        measure(1, 1);
        check("static_duty15", meas[0], 30);

        cfg_write(0, 1, 2, 0, a1, f1);
        cfg_write(0, 1, 6, 0, a2, f2);
        check("bp_accept_after_commit", a2 - f2, 1);
        measure(1, 1);
        check("bp_second_applied", meas[0], 12);

        cfg_write(1, 2, 15, 1, a1, f1);
        measure(2, 4);
        check("blink_f0", meas[0], 30);
        check("blink_f1", meas[1], 30);
        check("blink_f2", meas[2], 0);
        check("blink_f3", meas[3], 0);

        cfg_write(2, 3, 3, 0, a1, f1);
        measure(4, 8);
        check("breathe_f0", meas[0], 0);
        check("breathe_f1", meas[1], 2);
        check("breathe_f2", meas[2], 4);
        check("breathe_f3", meas[3], 6);
        check("breathe_f4", meas[4], 4);
        check("breathe_f5", meas[5], 2);
        check("breathe_f6", meas[6], 0);
        check("breathe_f7", meas[7], 2);

        cfg_write(3, 1, 9, 0, a1, f1);
        measure(7, 1);

        wait_fs();
        @(posedge clk);
        #1;
        cfg_write(0, 1, 8, 0, a1, f1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_ready", int'(cfg_if.cfg_ready), 1);
        measure(7, 2);
        check("midrst_off_f0", meas[0], 0);
        check("midrst_off_f1", meas[1], 0);

        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                      $urandom_range(0, 2), a1, f1);
        end
        repeat (3 * FRAME) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
